// File: rtl/keypad_entry_sequencer.sv
// Keypad entry sequencer: turns level-held scanner keys into single events, builds a BCD amount, handshakes it out.
// Optional inactivity auto-clear in ENTRY is compiled in with `define KEYPAD_ENTRY_TIMEOUT_EN.
module keypad_entry_sequencer #(
  parameter int MAX_DIGITS    = 2,
  parameter int TIMEOUT_TICKS = 10000,
  parameter int TMR_W         = 14
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [3:0]                         key_value,
  input  logic                               press_num,
  input  logic                               start,
  input  logic                               clear,
  input  logic                               confirm,
  input  logic                               amount_ack,
  output logic [4*MAX_DIGITS-1:0]            amount_bcd,
  output logic [$clog2(MAX_DIGITS+1)-1:0]    digit_cnt,
  output logic                               amount_valid,
  output logic                               start_req,
  output logic                               clear_req,
  output logic                               overflow,
  output logic                               timeout,
  output logic [1:0]                         state
);

  // state    | meaning
  // IDLE     | no amount entered
  // ENTRY    | collecting digits
  // WAIT_ACK | amount offered, waiting for charge controller
  // LOCKED   | amount accepted, waiting for START
  typedef enum logic [1:0] {IDLE = 2'd0, ENTRY = 2'd1, WAIT_ACK = 2'd2, LOCKED = 2'd3} state_t;

  localparam int AW = 4 * MAX_DIGITS;
  localparam int CW = $clog2(MAX_DIGITS + 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   amount_q, amount_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            start_req_d, clear_req_d, overflow_d, timeout_d;
  logic            prev_num, prev_start, prev_clear, prev_confirm, armed;
  logic            ev_num, ev_start, ev_clear, ev_confirm, any_ev;
  logic            act_confirm, act_start, act_digit;
  logic            tmr_hit;

  // armed masks the first post-reset cycle so a key held through reset is not seen as a press
  assign ev_num     = press_num & ~prev_num & armed;
  assign ev_start   = start & ~prev_start & armed;
  assign ev_clear   = clear & ~prev_clear & armed;
  assign ev_confirm = confirm & ~prev_confirm & armed;
  assign any_ev     = ev_num | ev_start | ev_clear | ev_confirm;

  assign act_confirm = ev_confirm & ~ev_clear;
  assign act_start   = ev_start & ~ev_confirm & ~ev_clear;
  assign act_digit   = ev_num & ~ev_start & ~ev_confirm & ~ev_clear;

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
  logic [TMR_W-1:0] tmr_q, tmr_d;

  assign tmr_hit = (tmr_q == TMR_W'(TIMEOUT_TICKS - 1));

  always_comb begin
    tmr_d = '0;
    if (state_q == ENTRY && !any_ev && !tmr_hit) tmr_d = tmr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) tmr_q <= '0;
    else       tmr_q <= tmr_d;
  end
`else
  logic unused_tmr_cfg;
  assign unused_tmr_cfg = ^{TMR_W[0], TIMEOUT_TICKS[0]};
  assign tmr_hit        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    amount_d    = amount_q;
    cnt_d       = cnt_q;
    start_req_d = 1'b0;
    clear_req_d = 1'b0;
    overflow_d  = 1'b0;
    timeout_d   = 1'b0;
    if (ev_clear) begin
      state_d     = IDLE;
      amount_d    = '0;
      cnt_d       = '0;
      clear_req_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (act_digit) begin
            amount_d = AW'(key_value);
            cnt_d    = CW'(1);
            state_d  = ENTRY;
          end
        end
        ENTRY: begin
          if (act_confirm) begin
            if (amount_q != '0) begin
              state_d = WAIT_ACK;
            end else begin
              state_d     = IDLE;
              amount_d    = '0;
              cnt_d       = '0;
              clear_req_d = 1'b1;
            end
          end else if (act_digit) begin
            if (cnt_q < CW'(MAX_DIGITS)) begin
              amount_d = (amount_q << 4) | AW'(key_value);
              cnt_d    = cnt_q + 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end else if (!any_ev && tmr_hit) begin
            state_d   = IDLE;
            amount_d  = '0;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end
        end
        WAIT_ACK: begin
          if (amount_ack) state_d = LOCKED;
        end
        LOCKED: begin
          if (act_start) begin
            state_d     = IDLE;
            amount_d    = '0;
            cnt_d       = '0;
            start_req_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= IDLE;
      amount_q     <= '0;
      cnt_q        <= '0;
      amount_valid <= 1'b0;
      start_req    <= 1'b0;
      clear_req    <= 1'b0;
      overflow     <= 1'b0;
      timeout      <= 1'b0;
      prev_num     <= 1'b0;
      prev_start   <= 1'b0;
      prev_clear   <= 1'b0;
      prev_confirm <= 1'b0;
      armed        <= 1'b0;
    end else begin
      state_q      <= state_d;
      amount_q     <= amount_d;
      cnt_q        <= cnt_d;
      amount_valid <= (state_d == WAIT_ACK);
      start_req    <= start_req_d;
      clear_req    <= clear_req_d;
      overflow     <= overflow_d;
      timeout      <= timeout_d;
      prev_num     <= press_num;
      prev_start   <= start;
      prev_clear   <= clear;
      prev_confirm <= confirm;
      armed        <= 1'b1;
    end
  end

  assign amount_bcd = amount_q;
  assign digit_cnt  = cnt_q;
  assign state      = state_q;

endmodule

// File: doc/keypad_entry_sequencer.md
Name: keypad_entry_sequencer

Overview:
- Sits between the 4x4 keypad scanner and the charge controller.
- Converts the scanner's level-held key flags (press_num, start, clear, confirm) into single key events.
- Assembles a multi-digit BCD amount, runs a confirm/acknowledge handshake with the charge controller, and issues one-cycle start/clear requests.
- Runs on the 1 kHz divided clock used by the scanner.

Parameters:
- MAX_DIGITS, 2, maximum BCD digits accepted (amount width 4*MAX_DIGITS).
- TIMEOUT_TICKS, 10000, idle clk cycles in ENTRY before auto-clear (10 s at 1 kHz).
- TMR_W, 14, inactivity timer width; must hold TIMEOUT_TICKS-1.

Ports:
- clk  input  1  1 kHz clock.
- rst_n  input  1  asynchronous, active-high reset.
- key_value  input  4  digit from scanner; valid while press_num high.
- press_num  input  1  level, number key held.
- start  input  1  level, START key held.
- clear  input  1  level, CLEAR key held.
- confirm  input  1  level, CONFIRM key held.
- amount_ack  input  1  charge controller accepted the amount.
- amount_bcd  output  4*MAX_DIGITS  entered amount, BCD, least-significant digit in [3:0].
- digit_cnt  output  $clog2(MAX_DIGITS+1)  digits entered.
- amount_valid  output  1  level, held high in WAIT_ACK.
- start_req  output  1  one-cycle pulse.
- clear_req  output  1  one-cycle pulse.
- overflow  output  1  one-cycle pulse, digit rejected.
- timeout  output  1  one-cycle pulse, inactivity auto-clear.
- state  output  2  IDLE=0, ENTRY=1, WAIT_ACK=2, LOCKED=3.

Behaviour:
- **Reset.** All outputs 0, state IDLE, edge registers 0, timer 0.
- **Edge detection.** Each of press_num/start/clear/confirm is registered. An event is signal=1 while its previous value is 0. key_value is captured in the press_num event cycle. A held key yields exactly one event.
- **Latency.** All outputs are registered; the response appears one clk after the cycle in which the rising level is first sampled.
- **Priority on simultaneous events.** clear > confirm > start > digit. Only the highest-priority event is acted on; the others are dropped.
- **clear, any state.** amount_bcd=0, digit_cnt=0, go to IDLE, clear_req pulse.
- **IDLE.**
  - digit event: amount_bcd={0..,d}, digit_cnt=1, go to ENTRY.
  - start and confirm events are ignored.
- **ENTRY.**
  - digit event with digit_cnt<MAX_DIGITS: amount_bcd shifts left by 4 with d appended; digit_cnt+1.
  - digit event with digit_cnt==MAX_DIGITS: amount unchanged, overflow pulse.
  - confirm event with amount_bcd!=0: go to WAIT_ACK.
  - confirm event with amount_bcd==0 (e.g. "00"): clear to IDLE, clear_req pulse.
  - start event: ignored.
- **WAIT_ACK.**
  - amount_valid=1; amount_bcd and digit_cnt frozen; digits, start and confirm ignored.
  - amount_ack=1 (level, sampled) → LOCKED, amount_valid=0 the next cycle.
  - clear has priority over an ack arriving in the same cycle.
- **LOCKED.**
  - amount held.
  - start event → start_req pulse, amount_bcd=0, digit_cnt=0, go to IDLE.
  - digits and confirm ignored.
- **Inactivity timer.**
  - Active only in ENTRY; zeroed on any event and on ENTRY entry.
  - Increments each clk; on reaching TIMEOUT_TICKS-1, behaves as clear but pulses timeout instead of clear_req.
  - Timer saturates and never wraps.
- **Reset mid-operation.** Immediate return to reset values. A key still held at reset release does not generate an event until it is released and pressed again, because the previous-value registers are loaded with the current inputs on the first post-reset clk.
- **Pulse outputs.** Never high for two consecutive cycles.

Optional Feature:
- Macro KEYPAD_ENTRY_TIMEOUT_EN.
- Defined: inactivity timer and timeout output behave as above.
- Undefined: no timer logic; timeout is tied 0; ENTRY persists indefinitely.

Test Plan:
- Press 3, release, press 7, release, press confirm → amount_bcd=8'h37, digit_cnt=2, amount_valid high until amount_ack; then state=LOCKED.
- After "3","7", press 5 → overflow single pulse; amount_bcd stays 8'h37.
- LOCKED with 8'h37, press start held for 20 cycles → exactly one start_req pulse; amount_bcd=0, state=IDLE.
- ENTRY with "4", clear and confirm rising in the same cycle → clear_req pulse, amount_bcd=0, IDLE, no amount_valid.
- Enter "0","0" then confirm → clear_req pulse, IDLE, amount_valid never asserted.
- With KEYPAD_ENTRY_TIMEOUT_EN defined, TIMEOUT_TICKS=20, enter "9" and wait 20 cycles → timeout pulse, IDLE, amount_bcd=0. Without the macro, state stays ENTRY.
